// File: rtl/pts_tx_nbit_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter slice.
package pts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pts_state_t;

  localparam logic PTS_IDLE_LEVEL = 1'b0;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pts_tx_nbit_if.sv
// Load handshake and serial output bundle for pts_tx_nbit.
interface pts_tx_nbit_if #(
  parameter int unsigned BIT_WIDTH = 4
);

  logic [BIT_WIDTH-1:0] par_in;
  logic                 load_valid;
  logic                 load_ready;
  logic                 ser_out;
  logic                 shift_en;
  logic                 busy;
  logic                 done;

  modport master (
    output par_in, load_valid,
    input  load_ready, ser_out, shift_en, busy, done
  );

  modport slave (
    input  par_in, load_valid,
    output load_ready, ser_out, shift_en, busy, done
  );

endinterface

// File: rtl/pts_tx_nbit_bit_timer.sv
// Bit-period counter: tick marks the last clock of each bit slot.
module pts_bit_timer
  import pts_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = ctr_width(BIT_PERIOD);
  localparam logic [PW-1:0] TERM = PW'(BIT_PERIOD - 1);

  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pts_tx_nbit.sv
// Parallel-to-serial transmitter: accepts a word on valid/ready and shifts it
// out bit by bit, strobing shift_en when the downstream receiver should sample.
module pts_tx_nbit
  import pts_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 4,
  parameter int unsigned BIT_PERIOD = 1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  pts_tx_nbit_if.slave  bus
);

  localparam int unsigned BW = ctr_width(BIT_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(BIT_WIDTH - 1);

  pts_state_t           state;
  logic [BIT_WIDTH-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 tick;
  logic                 in_idle;
  logic                 in_shift;

  assign in_idle  = (state == IDLE);
  assign in_shift = (state == SHIFT);

  // Period counter is held clear throughout IDLE, so it starts at zero on entry.
  pts_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (in_idle),
    .enable (in_shift),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            state   <= SHIFT;
            shreg   <= bus.par_in;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (MSB_FIRST) shreg <= {shreg[BIT_WIDTH-2:0], 1'b0};
            else           shreg <= {1'b0, shreg[BIT_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = in_idle;
  assign bus.busy       = in_shift;
  assign bus.shift_en   = tick;
  assign bus.done       = tick && (bit_cnt == LAST_BIT);
  assign bus.ser_out    = in_shift ? (MSB_FIRST ? shreg[BIT_WIDTH-1] : shreg[0])
                                   : PTS_IDLE_LEVEL;

endmodule

// File: tb/tb_pts_tx_nbit.sv
// Directed bench for pts_tx_nbit: three configurations, scoreboard of expected
// serial bits and received words, immediate-assertion checks.
module tb_pts_tx_nbit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [3:0] par_d [3];
  logic       lv_d  [3];
  logic       ser_a [3];
  logic       sen_a [3];
  logic       bsy_a [3];
  logic       dn_a  [3];
  logic       rdy_a [3];
  logic [3:0] rx    [3];

  logic       exp_q [$];
  logic [3:0] exp_w [$];

  pts_tx_nbit_if #(.BIT_WIDTH(4)) if0 ();
  pts_tx_nbit_if #(.BIT_WIDTH(4)) if1 ();
  pts_tx_nbit_if #(.BIT_WIDTH(4)) if2 ();

  pts_tx_nbit #(.BIT_WIDTH(4), .BIT_PERIOD(1), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pts_tx_nbit #(.BIT_WIDTH(4), .BIT_PERIOD(1), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  pts_tx_nbit #(.BIT_WIDTH(4), .BIT_PERIOD(3), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.par_in = par_d[0]; assign if0.load_valid = lv_d[0];
  assign if1.par_in = par_d[1]; assign if1.load_valid = lv_d[1];
  assign if2.par_in = par_d[2]; assign if2.load_valid = lv_d[2];

  assign ser_a[0] = if0.ser_out; assign sen_a[0] = if0.shift_en; assign bsy_a[0] = if0.busy;
  assign dn_a[0]  = if0.done;    assign rdy_a[0] = if0.load_ready;
  assign ser_a[1] = if1.ser_out; assign sen_a[1] = if1.shift_en; assign bsy_a[1] = if1.busy;
  assign dn_a[1]  = if1.done;    assign rdy_a[1] = if1.load_ready;
  assign ser_a[2] = if2.ser_out; assign sen_a[2] = if2.shift_en; assign bsy_a[2] = if2.busy;
  assign dn_a[2]  = if2.done;    assign rdy_a[2] = if2.load_ready;

  // Downstream serial-to-parallel receiver model, shifting in at the LSB.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) rx[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (sen_a[i]) rx[i] <= {rx[i][2:0], ser_a[i]};
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int unsigned d, input string tag);
    check({tag, "_ser"},   {7'd0, ser_a[d]}, 8'd0);
    check({tag, "_sen"},   {7'd0, sen_a[d]}, 8'd0);
    check({tag, "_done"},  {7'd0, dn_a[d]},  8'd0);
    check({tag, "_busy"},  {7'd0, bsy_a[d]}, 8'd0);
    check({tag, "_ready"}, {7'd0, rdy_a[d]}, 8'd1);
  endtask

  // Called at a negedge while the DUT is idle; handshake happens at the next posedge.
  task automatic xfer(input int unsigned d, input logic [3:0] w, input int unsigned per,
                      input bit msb, input bit hold, input bit abort);
    logic eb [4];
    logic popped;
    for (int unsigned i = 0; i < 4; i++) begin
      eb[i] = msb ? w[3-i] : w[i];
      exp_q.push_back(eb[i]);
    end
    exp_w.push_back(msb ? w : {w[0], w[1], w[2], w[3]});
    check("ready_before_load", {7'd0, rdy_a[d]}, 8'd1);
    par_d[d] = w;
    lv_d[d]  = 1'b1;
    @(posedge clk);
    for (int unsigned c = 1; c <= 4 * per; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) par_d[d] = 4'b1111;
        else      lv_d[d]  = 1'b0;
      end
      check("ser_bit",   {7'd0, ser_a[d]}, {7'd0, eb[(c-1)/per]});
      check("busy_shift", {7'd0, bsy_a[d]}, 8'd1);
      check("ready_shift", {7'd0, rdy_a[d]}, 8'd0);
      check("shift_en",  {7'd0, sen_a[d]}, {7'd0, (c % per) == 0});
      check("done",      {7'd0, dn_a[d]},  {7'd0, c == 4 * per});
      if (sen_a[d] === 1'b1) begin
        popped = exp_q.pop_front();
        check("sb_bit", {7'd0, ser_a[d]}, {7'd0, popped});
      end
      if (abort && c == 2 * per) begin
        rst = 1'b1;
        #1;
        check_idle(d, "abort");
        for (int unsigned r = 0; r < 3; r++) begin
          @(negedge clk);
          check_idle(d, "in_reset");
        end
        rst = 1'b0;
        exp_q.delete();
        exp_w.delete();
        return;
      end
    end
    @(negedge clk);
    check_idle(d, "after_word");
    check("sb_empty", 8'(exp_q.size()), 8'd0);
    check("rx_word", {4'd0, rx[d]}, {4'd0, exp_w.pop_front()});
  endtask

  initial begin
    rst = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      par_d[i] = '0;
      lv_d[i]  = 1'b0;
    end
    #1;
    for (int unsigned i = 0; i < 3; i++) check_idle(i, "reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) check_idle(i, "post_reset");

    xfer(0, 4'b1101, 1, 1'b1, 1'b0, 1'b0);
    xfer(1, 4'b1101, 1, 1'b0, 1'b0, 1'b0);
    xfer(2, 4'b1001, 3, 1'b1, 1'b0, 1'b0);
    xfer(0, 4'b0110, 1, 1'b1, 1'b1, 1'b0);
    xfer(0, 4'b1111, 1, 1'b1, 1'b0, 1'b0);
    xfer(0, 4'b1010, 1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_idle(0, "post_abort");
    xfer(0, 4'b0011, 1, 1'b1, 1'b0, 1'b0);
    xfer(2, 4'b0110, 3, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    xfer(2, 4'b0101, 3, 1'b1, 1'b0, 1'b0);
    xfer(1, 4'b0011, 1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
